tmr_updown_counter: RTL and testbench

//  Parametrised triple-modular-redundant up/down counter. Successor to the fixed 128-bit TMR counter.

---
 rtl/tmr_pkg.sv | 6 +
 rtl/tmr_updown_counter_if.sv | 30 +++
 rtl/tmr_vote.sv | 17 +
 rtl/tmr_updown_counter.sv | 102 ++++++++++
 tb/tb_tmr_updown_counter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared constants and types for the TMR up/down counter
package tmr_pkg;
    localparam int NREP = 3;
    typedef logic [1:0]      rep_idx_t;
    typedef logic [NREP-1:0] rep_vec_t;
endpackage

// File: rtl/tmr_updown_counter_if.sv
// rtl/tmr_updown_counter_if.sv - control/status bundle of the TMR up/down counter
interface tmr_updown_counter_if
    import tmr_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int ECW   = 8
);
    logic                    en_i;
    logic                    up_i;
    logic                    load_i;
    logic [WIDTH-1:0]        load_val_i;
    logic                    clr_err_i;
    rep_vec_t                inj_en_i;
    logic [NREP*WIDTH-1:0]   inj_mask_i;
    logic [WIDTH-1:0]        count_o;
    logic                    tc_o;
    rep_vec_t                mismatch_o;
    logic                    triple_err_o;
    rep_vec_t                failed_o;
    logic [NREP*ECW-1:0]     err_cnt_o;

    modport master (
        output en_i, up_i, load_i, load_val_i, clr_err_i, inj_en_i, inj_mask_i,
        input  count_o, tc_o, mismatch_o, triple_err_o, failed_o, err_cnt_o
    );
    modport slave (
        input  en_i, up_i, load_i, load_val_i, clr_err_i, inj_en_i, inj_mask_i,
        output count_o, tc_o, mismatch_o, triple_err_o, failed_o, err_cnt_o
    );
endinterface

// File: rtl/tmr_vote.sv
// rtl/tmr_vote.sv - bitwise 2-of-3 majority voter with per-replica disagreement flags
module tmr_vote
    import tmr_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] i_r0,
    input  logic [WIDTH-1:0] i_r1,
    input  logic [WIDTH-1:0] i_r2,
    output logic [WIDTH-1:0] o_v,
    output rep_vec_t         o_mismatch,
    output logic             o_triple
);
    assign o_v        = (i_r0 & i_r1) | (i_r0 & i_r2) | (i_r1 & i_r2);
    assign o_mismatch = {(i_r2 != o_v), (i_r1 != o_v), (i_r0 != o_v)};
    assign o_triple   = (i_r0 != i_r1) && (i_r0 != i_r2) && (i_r1 != i_r2);
endmodule

// File: rtl/tmr_updown_counter.sv
// rtl/tmr_updown_counter.sv - triple-redundant up/down counter with scrubbing and error accounting
module tmr_updown_counter
    import tmr_pkg::*;
#(
    parameter int               WIDTH       = 128,
    parameter logic [WIDTH-1:0] STEP        = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit               SATURATE    = 1'b0,
    parameter int               ECW         = 8,
    parameter int               FAIL_THRESH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    tmr_updown_counter_if.slave  bus
);
    logic [WIDTH-1:0] w_rep [NREP];
    logic [WIDTH-1:0] w_v;
    rep_vec_t         w_mismatch;
    logic             w_triple;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_nx;
    logic             w_tc_nx;
    logic             r_tc;
    logic             r_triple;

    tmr_vote #(.WIDTH(WIDTH)) u_vote (
        .i_r0       (w_rep[0]),
        .i_r1       (w_rep[1]),
        .i_r2       (w_rep[2]),
        .o_v        (w_v),
        .o_mismatch (w_mismatch),
        .o_triple   (w_triple)
    );

    // Extra top bit carries the overflow/underflow that drives wrap and clamp.
    assign w_sum = {1'b0, w_v} + {1'b0, STEP};
    assign w_dif = {1'b0, w_v} - {1'b0, STEP};

    always_comb begin
        w_nx    = w_v;
        w_tc_nx = 1'b0;
        if (bus.load_i) begin
            w_nx = bus.load_val_i;
        end else if (bus.en_i && bus.up_i) begin
            w_nx    = w_sum[WIDTH-1:0];
            w_tc_nx = w_sum[WIDTH];
            if (SATURATE && w_sum[WIDTH]) w_nx = '1;
        end else if (bus.en_i) begin
            w_nx    = w_dif[WIDTH-1:0];
            w_tc_nx = w_dif[WIDTH];
            if (SATURATE && w_dif[WIDTH]) w_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc     <= 1'b0;
            r_triple <= 1'b0;
        end else begin
            r_tc     <= w_tc_nx;
            r_triple <= bus.clr_err_i ? 1'b0 : (r_triple | w_triple);
        end
    end

    for (genvar gi = 0; gi < NREP; gi++) begin : g_rep
        logic [WIDTH-1:0] r_rep;
        logic [ECW-1:0]   r_err;
        logic             r_failed;
        logic [WIDTH-1:0] w_mask;
        logic [ECW-1:0]   w_err_inc;

        assign w_mask    = bus.inj_en_i[gi] ? bus.inj_mask_i[gi*WIDTH +: WIDTH] : '0;
        assign w_err_inc = (w_mismatch[gi] && (r_err != '1)) ? r_err + 1'b1 : r_err;

        // Every replica reloads from the vote each edge, so an upset lives one cycle at most.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep    <= '0;
                r_err    <= '0;
                r_failed <= 1'b0;
            end else begin
                r_rep <= w_nx ^ w_mask;
                if (bus.clr_err_i) begin
                    r_err    <= '0;
                    r_failed <= 1'b0;
                end else begin
                    r_err    <= w_err_inc;
                    r_failed <= r_failed | (w_err_inc >= ECW'(FAIL_THRESH));
                end
            end
        end

        assign w_rep[gi]                   = r_rep;
        assign bus.failed_o[gi]            = r_failed;
        assign bus.err_cnt_o[gi*ECW +: ECW] = r_err;
    end

    assign bus.count_o      = w_v;
    assign bus.tc_o         = r_tc;
    assign bus.mismatch_o   = w_mismatch;
    assign bus.triple_err_o = r_triple;
endmodule

// File: tb/tb_tmr_updown_counter.sv
// tb/tb_tmr_updown_counter.sv - self-checking bench for the TMR up/down counter
module tb_tmr_updown_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, up = 1'b0, load = 1'b0, clr = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic [2:0]  inj_en = 3'b000;
    logic [23:0] inj_mask = 24'h0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: [0] wrapping counter, [1] saturating counter
    int          m_rep [2][3];
    int          m_err [2][3];
    logic [2:0]  m_failed [2];
    logic        m_triple [2];
    logic        m_tc [2];

    tmr_updown_counter_if #(.WIDTH(8), .ECW(4)) bw ();
    tmr_updown_counter_if #(.WIDTH(8), .ECW(4)) bs ();

    assign bw.en_i = en;       assign bs.en_i = en;
    assign bw.up_i = up;       assign bs.up_i = up;
    assign bw.load_i = load;   assign bs.load_i = load;
    assign bw.load_val_i = load_val;  assign bs.load_val_i = load_val;
    assign bw.clr_err_i = clr; assign bs.clr_err_i = clr;
    assign bw.inj_en_i = inj_en;      assign bs.inj_en_i = inj_en;
    assign bw.inj_mask_i = inj_mask;  assign bs.inj_mask_i = inj_mask;

    tmr_updown_counter #(.WIDTH(8), .STEP(8'd1), .SATURATE(1'b0), .ECW(4), .FAIL_THRESH(3))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));
    tmr_updown_counter #(.WIDTH(8), .STEP(8'd1), .SATURATE(1'b1), .ECW(4), .FAIL_THRESH(3))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(bs));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int maj3(int a, int b, int c);
        int r = 0;
        for (int k = 0; k < 8; k++) begin
            if ((((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1)) >= 2) r = r | (1 << k);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                m_rep[k][i] = 0;
                m_err[k][i] = 0;
            end
            m_failed[k] = 3'b000;
            m_triple[k] = 1'b0;
            m_tc[k]     = 1'b0;
        end
    endtask

    task automatic model_step();
        int v, s, nx;
        bit trip;
        for (int k = 0; k < 2; k++) begin
            v    = maj3(m_rep[k][0], m_rep[k][1], m_rep[k][2]);
            trip = (m_rep[k][0] != m_rep[k][1]) && (m_rep[k][0] != m_rep[k][2]) &&
                   (m_rep[k][1] != m_rep[k][2]);
            if (clr) begin
                for (int i = 0; i < 3; i++) m_err[k][i] = 0;
                m_failed[k] = 3'b000;
                m_triple[k] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (m_rep[k][i] != v && m_err[k][i] < 15) m_err[k][i]++;
                    if (m_err[k][i] >= 3) m_failed[k][i] = 1'b1;
                end
                m_triple[k] = m_triple[k] | trip;
            end
            nx = v;
            m_tc[k] = 1'b0;
            if (load) begin
                nx = int'(load_val);
            end else if (en) begin
                s = up ? v + 1 : v - 1;
                if (s > 255 || s < 0) begin
                    m_tc[k] = 1'b1;
                    nx = (k == 1) ? (up ? 255 : 0) : (s & 255);
                end else begin
                    nx = s;
                end
            end
            for (int i = 0; i < 3; i++)
                m_rep[k][i] = nx ^ (inj_en[i] ? int'((inj_mask >> (8 * i)) & 24'hFF) : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bw.count_o !== 8'h00) begin n_errors++; $display("FAIL reset_count_w: got %h exp 00", bw.count_o); end
        n_checks++; if (bs.count_o !== 8'h00) begin n_errors++; $display("FAIL reset_count_s: got %h exp 00", bs.count_o); end
        n_checks++; if ({bw.tc_o, bw.mismatch_o, bw.triple_err_o, bw.failed_o} !== 8'h00) begin n_errors++; $display("FAIL reset_flags: got %b exp 0", {bw.tc_o, bw.mismatch_o, bw.triple_err_o, bw.failed_o}); end
        n_checks++; if (bw.err_cnt_o !== 12'h000) begin n_errors++; $display("FAIL reset_err: got %h exp 000", bw.err_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (bw.tc_o !== 1'b0) begin n_errors++; $display("FAIL up_tc[%0d]: got %b exp 0", i, bw.tc_o); end
        end
        n_checks++; if (bw.count_o !== 8'h05) begin n_errors++; $display("FAIL up5_count: got %h exp 05", bw.count_o); end
        n_checks++; if (bs.count_o !== 8'h05) begin n_errors++; $display("FAIL up5_count_s: got %h exp 05", bs.count_o); end
        n_checks++; if (bw.mismatch_o !== 3'b000) begin n_errors++; $display("FAIL up5_mismatch: got %b exp 000", bw.mismatch_o); end
    endtask

    task automatic test_inject_single();
        inj_en = 3'b010; inj_mask = 24'h000100;
        tick();
        inj_en = 3'b000; inj_mask = 24'h0;
        n_checks++; if (bw.count_o !== 8'h06) begin n_errors++; $display("FAIL inj1_count: got %h exp 06", bw.count_o); end
        n_checks++; if (bw.mismatch_o !== 3'b010) begin n_errors++; $display("FAIL inj1_mismatch: got %b exp 010", bw.mismatch_o); end
        tick();
        en = 1'b0;
        n_checks++; if (bw.count_o !== 8'h07) begin n_errors++; $display("FAIL inj1_scrub_count: got %h exp 07", bw.count_o); end
        n_checks++; if (bw.mismatch_o !== 3'b000) begin n_errors++; $display("FAIL inj1_scrub_mismatch: got %b exp 000", bw.mismatch_o); end
        n_checks++; if (bw.err_cnt_o[7:4] !== 4'd1) begin n_errors++; $display("FAIL inj1_err1: got %0d exp 1", bw.err_cnt_o[7:4]); end
    endtask

    task automatic test_wrap_saturate();
        load = 1'b1; load_val = 8'hFF;
        tick();
        load = 1'b0;
        n_checks++; if (bw.count_o !== 8'hFF || bw.tc_o !== 1'b0) begin n_errors++; $display("FAIL load_ff: got %h/%b exp ff/0", bw.count_o, bw.tc_o); end
        en = 1'b1; up = 1'b1;
        tick();
        en = 1'b0;
        n_checks++; if (bw.count_o !== 8'h00 || bw.tc_o !== 1'b1) begin n_errors++; $display("FAIL wrap_up: got %h/%b exp 00/1", bw.count_o, bw.tc_o); end
        n_checks++; if (bs.count_o !== 8'hFF || bs.tc_o !== 1'b1) begin n_errors++; $display("FAIL sat_up: got %h/%b exp ff/1", bs.count_o, bs.tc_o); end
        tick();
        n_checks++; if (bw.tc_o !== 1'b0 || bs.tc_o !== 1'b0) begin n_errors++; $display("FAIL tc_pulse: got %b%b exp 00", bw.tc_o, bs.tc_o); end
        load = 1'b1; load_val = 8'h00;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        en = 1'b0;
        n_checks++; if (bw.count_o !== 8'hFF || bw.tc_o !== 1'b1) begin n_errors++; $display("FAIL wrap_down: got %h/%b exp ff/1", bw.count_o, bw.tc_o); end
        n_checks++; if (bs.count_o !== 8'h00 || bs.tc_o !== 1'b1) begin n_errors++; $display("FAIL sat_down: got %h/%b exp 00/1", bs.count_o, bs.tc_o); end
    endtask

    task automatic test_triple();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load = 1'b1; load_val = 8'h10; inj_en = 3'b111; inj_mask = 24'h040201;
        tick();
        load = 1'b0; inj_en = 3'b000; inj_mask = 24'h0;
        n_checks++; if (bw.count_o !== 8'h10) begin n_errors++; $display("FAIL triple_vote: got %h exp 10", bw.count_o); end
        n_checks++; if (bw.mismatch_o !== 3'b111) begin n_errors++; $display("FAIL triple_mismatch: got %b exp 111", bw.mismatch_o); end
        tick();
        n_checks++; if (bw.triple_err_o !== 1'b1) begin n_errors++; $display("FAIL triple_set: got %b exp 1", bw.triple_err_o); end
        n_checks++; if (bw.mismatch_o !== 3'b000) begin n_errors++; $display("FAIL triple_scrub: got %b exp 000", bw.mismatch_o); end
        n_checks++; if (bw.err_cnt_o !== 12'h111) begin n_errors++; $display("FAIL triple_err: got %h exp 111", bw.err_cnt_o); end
        tick();
        n_checks++; if (bw.triple_err_o !== 1'b1) begin n_errors++; $display("FAIL triple_sticky: got %b exp 1", bw.triple_err_o); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (bw.triple_err_o !== 1'b0 || bw.err_cnt_o !== 12'h000) begin n_errors++; $display("FAIL triple_clr: got %b/%h exp 0/000", bw.triple_err_o, bw.err_cnt_o); end
    endtask

    task automatic test_fail_thresh();
        for (int i = 0; i < 3; i++) begin
            inj_en = 3'b100; inj_mask = 24'h010000;
            tick();
            inj_en = 3'b000; inj_mask = 24'h0;
            n_checks++; if (bw.mismatch_o !== 3'b100) begin n_errors++; $display("FAIL thr_mismatch[%0d]: got %b exp 100", i, bw.mismatch_o); end
            tick();
            n_checks++; if (bw.err_cnt_o[11:8] !== 4'(i + 1)) begin n_errors++; $display("FAIL thr_err2[%0d]: got %0d exp %0d", i, bw.err_cnt_o[11:8], i + 1); end
            n_checks++; if (bw.failed_o !== ((i == 2) ? 3'b100 : 3'b000)) begin n_errors++; $display("FAIL thr_failed[%0d]: got %b", i, bw.failed_o); end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (bw.err_cnt_o !== 12'h000 || bw.failed_o !== 3'b000) begin n_errors++; $display("FAIL thr_clr: got %h/%b exp 000/000", bw.err_cnt_o, bw.failed_o); end
        inj_en = 3'b100; inj_mask = 24'h010000;
        tick();
        inj_en = 3'b000; inj_mask = 24'h0; clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++; if (bw.err_cnt_o !== 12'h000 || bw.failed_o !== 3'b000) begin n_errors++; $display("FAIL clr_wins: got %h/%b exp 000/000", bw.err_cnt_o, bw.failed_o); end
        tick();
        n_checks++; if (bw.err_cnt_o !== 12'h000) begin n_errors++; $display("FAIL clr_after: got %h exp 000", bw.err_cnt_o); end
    endtask

    task automatic test_load_and_async_reset();
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h40;
        tick();
        load = 1'b0;
        n_checks++; if (bw.count_o !== 8'h40 || bw.tc_o !== 1'b0) begin n_errors++; $display("FAIL load_prio: got %h/%b exp 40/0", bw.count_o, bw.tc_o); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bw.count_o !== 8'h00 || bs.count_o !== 8'h00) begin n_errors++; $display("FAIL async_count: got %h/%h exp 00/00", bw.count_o, bs.count_o); end
        n_checks++; if ({bw.tc_o, bw.mismatch_o, bw.triple_err_o, bw.failed_o, bw.err_cnt_o} !== 20'h0) begin n_errors++; $display("FAIL async_flags: got %h exp 0", {bw.tc_o, bw.mismatch_o, bw.triple_err_o, bw.failed_o, bw.err_cnt_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        en = 1'b0;
        n_checks++; if (bw.count_o !== 8'h01) begin n_errors++; $display("FAIL async_restart: got %h exp 01", bw.count_o); end
    endtask

    task automatic test_random();
        logic [7:0]  g_c;
        logic        g_tc, g_tr;
        logic [2:0]  g_mis, g_fail, e_mis;
        logic [11:0] g_err, e_err;
        int          e_c;
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: load_val = 8'h00;
                1: load_val = 8'hFF;
                2: load_val = 8'hFE;
                default: load_val = 8'($urandom);
            endcase
            inj_en   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            inj_mask = 24'($urandom);
            clr      = ($urandom_range(0, 31) == 0);
            model_step();
            tick();
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    g_c = bw.count_o; g_tc = bw.tc_o; g_mis = bw.mismatch_o;
                    g_tr = bw.triple_err_o; g_fail = bw.failed_o; g_err = bw.err_cnt_o;
                end else begin
                    g_c = bs.count_o; g_tc = bs.tc_o; g_mis = bs.mismatch_o;
                    g_tr = bs.triple_err_o; g_fail = bs.failed_o; g_err = bs.err_cnt_o;
                end
                e_c = maj3(m_rep[k][0], m_rep[k][1], m_rep[k][2]);
                for (int i = 0; i < 3; i++) e_mis[i] = (m_rep[k][i] != e_c);
                e_err = {4'(m_err[k][2]), 4'(m_err[k][1]), 4'(m_err[k][0])};
                n_checks++; if (g_c !== 8'(e_c)) begin n_errors++; $display("FAIL rnd_count[%0d,%0d]: got %h exp %h", n, k, g_c, 8'(e_c)); end
                n_checks++; if (g_tc !== m_tc[k]) begin n_errors++; $display("FAIL rnd_tc[%0d,%0d]: got %b exp %b", n, k, g_tc, m_tc[k]); end
                n_checks++; if (g_mis !== e_mis) begin n_errors++; $display("FAIL rnd_mismatch[%0d,%0d]: got %b exp %b", n, k, g_mis, e_mis); end
                n_checks++; if (g_tr !== m_triple[k]) begin n_errors++; $display("FAIL rnd_triple[%0d,%0d]: got %b exp %b", n, k, g_tr, m_triple[k]); end
                n_checks++; if (g_fail !== m_failed[k]) begin n_errors++; $display("FAIL rnd_failed[%0d,%0d]: got %b exp %b", n, k, g_fail, m_failed[k]); end
                n_checks++; if (g_err !== e_err) begin n_errors++; $display("FAIL rnd_err[%0d,%0d]: got %h exp %h", n, k, g_err, e_err); end
            end
        end
        en = 1'b0; load = 1'b0; clr = 1'b0; inj_en = 3'b000;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_inject_single();
        test_wrap_saturate();
        test_triple();
        test_fail_thresh();
        test_load_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
